// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: address
// fields, FSM encodings and byte-lane helpers.
package dcache_defs;

    localparam int unsigned ADDR_WIDTH      = 8;
    localparam int unsigned INDEX_BITS      = 3;
    localparam int unsigned OFFSET_BITS     = 2;
    localparam int unsigned STAT_WIDTH      = 16;

    localparam int unsigned BYTE_BITS       = 8;
    localparam int unsigned BLOCK_BITS      = 32;
    localparam int unsigned NUM_BLOCKS      = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS        = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned BLOCK_ADDR_BITS = ADDR_WIDTH - OFFSET_BITS;
    localparam int unsigned BYTE_SEL_SHIFT  = 3;

    localparam logic [1:0] DC_IDLE      = 2'd0;
    localparam logic [1:0] DC_WRITEBACK = 2'd1;
    localparam logic [1:0] DC_FETCH     = 2'd2;

    typedef struct packed {
        logic [TAG_BITS-1:0]    tag;
        logic [INDEX_BITS-1:0]  index;
        logic [OFFSET_BITS-1:0] offset;
    } dc_addr_t;

    // Extract one byte lane of a block; lane 0 sits in bits [7:0].
    function automatic logic [BYTE_BITS-1:0] dc_get_byte(
        input logic [BLOCK_BITS-1:0]  blk,
        input logic [OFFSET_BITS-1:0] off
    );
        return blk[{off, 3'b000} +: BYTE_BITS];
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Block storage for dcache: valid/dirty flags (async cleared), tags and data,
// with a byte-write port, a block-install port and combinational lookup.
module dcache_store
    import dcache_defs::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_BITS-1:0]  i_index,
    input  logic [TAG_BITS-1:0]    i_tag,
    input  logic                   i_wr_en,
    input  logic [OFFSET_BITS-1:0] i_wr_offset,
    input  logic [BYTE_BITS-1:0]   i_wr_byte,
    input  logic                   i_fill_en,
    input  logic [TAG_BITS-1:0]    i_fill_tag,
    input  logic [BLOCK_BITS-1:0]  i_fill_data,
    output logic                   o_hit,
    output logic                   o_dirty,
    output logic [TAG_BITS-1:0]    o_tag,
    output logic [BLOCK_BITS-1:0]  o_data
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TAG_BITS-1:0]   r_tag  [NUM_BLOCKS];
    logic [BLOCK_BITS-1:0] r_data [NUM_BLOCKS];

    // Only the flags are reset; stale tags/data are harmless once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_wr_en) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_data[i_index] <= i_fill_data;
            r_tag[i_index]  <= i_fill_tag;
        end else if (i_wr_en) begin
            r_data[i_index][{i_wr_offset, 3'b000} +: BYTE_BITS] <= i_wr_byte;
        end
    end

    assign o_hit   = r_valid[i_index] && (r_tag[i_index] == i_tag);
    assign o_dirty = r_valid[i_index] && r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back/write-allocate data cache between a byte CPU port
// and a 32-bit block memory. Define DCACHE_STATS_EN to add hit/miss counters.
module dcache
    import dcache_defs::*;
(
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       READ,
    input  logic                       WRITE,
    input  logic [ADDR_WIDTH-1:0]      ADDRESS,
    input  logic [BYTE_BITS-1:0]       WRITEDATA,
    output logic [BYTE_BITS-1:0]       READDATA,
    output logic                       BUSYWAIT,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [BLOCK_ADDR_BITS-1:0] mem_address,
    output logic [BLOCK_BITS-1:0]      mem_writedata,
    input  logic [BLOCK_BITS-1:0]      mem_readdata,
    input  logic                       mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]      hit_count,
    output logic [STAT_WIDTH-1:0]      miss_count
`endif
);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [TAG_BITS-1:0]   r_miss_tag;
    logic [INDEX_BITS-1:0] r_miss_index;

    dc_addr_t              w_cpu_addr;
    logic                  w_req;
    logic                  w_idle;
    logic [INDEX_BITS-1:0] w_index;
    logic                  w_hit;
    logic                  w_dirty;
    logic [TAG_BITS-1:0]   w_tag;
    logic [BLOCK_BITS-1:0] w_data;
    logic                  w_idle_hit;
    logic                  w_miss_start;
    logic                  w_wr_en;
    logic                  w_fill_en;

    assign w_cpu_addr   = dc_addr_t'(ADDRESS);
    assign w_req        = READ | WRITE;
    assign w_idle       = (r_state == DC_IDLE);
    // Outside IDLE the store is addressed by the latched miss, not the live bus.
    assign w_index      = w_idle ? w_cpu_addr.index : r_miss_index;
    assign w_idle_hit   = w_idle && w_hit;
    assign w_miss_start = w_idle && w_req && !w_hit;
    assign w_wr_en      = w_idle_hit && WRITE;
    assign w_fill_en    = (r_state == DC_FETCH) && !mem_busywait;

    dcache_store u_store (
        .clk         (CLK),
        .rst_n       (RESET),
        .i_index     (w_index),
        .i_tag       (w_cpu_addr.tag),
        .i_wr_en     (w_wr_en),
        .i_wr_offset (w_cpu_addr.offset),
        .i_wr_byte   (WRITEDATA),
        .i_fill_en   (w_fill_en),
        .i_fill_tag  (r_miss_tag),
        .i_fill_data (mem_readdata),
        .o_hit       (w_hit),
        .o_dirty     (w_dirty),
        .o_tag       (w_tag),
        .o_data      (w_data)
    );

    assign BUSYWAIT = w_req && !w_idle_hit;
    assign READDATA = w_idle_hit ? dc_get_byte(w_data, w_cpu_addr.offset) : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= DC_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the missing block so the memory transaction survives a dropped request.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_miss_tag   <= '0;
            r_miss_index <= '0;
        end else if (w_miss_start) begin
            r_miss_tag   <= w_cpu_addr.tag;
            r_miss_index <= w_cpu_addr.index;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (r_state)
            DC_IDLE: begin
                if (w_miss_start) begin
                    w_next_state = w_dirty ? DC_WRITEBACK : DC_FETCH;
                end
            end
            DC_WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {w_tag, r_miss_index};
                mem_writedata = w_data;
                if (!mem_busywait) begin
                    w_next_state = DC_FETCH;
                end
            end
            DC_FETCH: begin
                mem_read    = 1'b1;
                mem_address = {r_miss_tag, r_miss_index};
                if (!mem_busywait) begin
                    w_next_state = DC_IDLE;
                end
            end
            default: begin
                w_next_state = DC_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [STAT_WIDTH-1:0] r_hit_count;
    logic [STAT_WIDTH-1:0] r_miss_count;
    logic                  r_missed;

    // r_missed suppresses counting the completion hit that follows a fill.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_missed     <= 1'b0;
        end else if (w_miss_start) begin
            r_missed <= 1'b1;
            if (r_miss_count != '1) begin
                r_miss_count <= r_miss_count + STAT_WIDTH'(1);
            end
        end else if (w_idle) begin
            if (w_req && !r_missed && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + STAT_WIDTH'(1);
            end
            r_missed <= 1'b0;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, reset corner case and
// randomized traffic against a flat-memory reference model.
module tb_dcache;
    import dcache_defs::*;

    logic                       CLK = 1'b0;
    logic                       RESET = 1'b0;
    logic                       READ = 1'b0;
    logic                       WRITE = 1'b0;
    logic [ADDR_WIDTH-1:0]      ADDRESS = '0;
    logic [BYTE_BITS-1:0]       WRITEDATA = '0;
    logic [BYTE_BITS-1:0]       READDATA;
    logic                       BUSYWAIT;
    logic                       mem_read;
    logic                       mem_write;
    logic [BLOCK_ADDR_BITS-1:0] mem_address;
    logic [BLOCK_BITS-1:0]      mem_writedata;
    logic [BLOCK_BITS-1:0]      mem_readdata;
    logic                       mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [STAT_WIDTH-1:0]      hit_count;
    logic [STAT_WIDTH-1:0]      miss_count;
`endif

    int checks = 0;
    int failures = 0;
    int lat = 5;
    int cnt = 0;
    int both_high_seen = 0;
    logic [31:0] mem [64];

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;
    txn_t mem_log[$];

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        int          exp_stall;
        bit          exp_wb;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        bit          exp_fetch;
        logic [5:0]  fetch_addr;
    } vec_t;
    vec_t vecs[7];

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory: busy for 'lat' cycles from the cycle a request appears, then one done cycle.
    assign mem_busywait = (mem_read || mem_write) && (cnt < lat);
    assign mem_readdata = mem[mem_address];

    always @(posedge CLK) begin
        if ((mem_read || mem_write) && !mem_busywait)
            mem_log.push_back(txn_t'{mem_write, mem_address, mem_writedata});
        if (!(mem_read || mem_write) || !mem_busywait) cnt <= 0;
        else cnt <= cnt + 1;
    end

    always @(negedge CLK) begin
        if (mem_read && mem_write) both_high_seen <= both_high_seen + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        READ  = 1'b0;
        WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // One CPU access held until BUSYWAIT is low; memory writebacks are applied afterwards.
    task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output int stalls, output int log_start);
        @(negedge CLK);
        log_start = mem_log.size();
        READ      = ~wr;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = wd;
        stalls    = 0;
        #1;
        while (BUSYWAIT && stalls < 200) begin
            @(negedge CLK);
            #1;
            stalls++;
        end
        chk("busywait_bound", 32'(BUSYWAIT), 32'd0);
        rd = READDATA;
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
        for (int k = log_start; k < mem_log.size(); k++)
            if (mem_log[k].wr) mem[mem_log[k].addr] = mem_log[k].data;
    endtask

    logic [7:0] ref_bytes [256];
    bit         mv [8];
    bit         md [8];
    logic [2:0] mt [8];

    initial begin
        logic [7:0] rd;
        int st, ls, n_exp, k, exp_stall, exp_hits, exp_misses;
        bit wr;
        logic [7:0] a, wd;
        logic [2:0] idx, tg;

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[6'h09] = 32'hDDCCBBAA;
        mem[6'h11] = 32'h44332211;
        mem[6'h01] = 32'h0F0E0D0C;
        mem[6'h21] = 32'h8F8E8D8C;

        vecs[0] = '{1'b0, 8'h25, 8'h00, 8'hBB, 7,  1'b0, 6'h00, 32'h0,        1'b1, 6'h09};
        vecs[1] = '{1'b0, 8'h24, 8'h00, 8'hAA, 0,  1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
        vecs[2] = '{1'b1, 8'h26, 8'h77, 8'h00, 0,  1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
        vecs[3] = '{1'b0, 8'h46, 8'h00, 8'h33, 13, 1'b1, 6'h09, 32'hDD77BBAA, 1'b1, 6'h11};
        vecs[4] = '{1'b0, 8'h26, 8'h00, 8'h77, 7,  1'b0, 6'h00, 32'h0,        1'b1, 6'h09};
        vecs[5] = '{1'b0, 8'h05, 8'h00, 8'h0D, 7,  1'b0, 6'h00, 32'h0,        1'b1, 6'h01};
        vecs[6] = '{1'b0, 8'h85, 8'h00, 8'h8D, 7,  1'b0, 6'h00, 32'h0,        1'b1, 6'h21};

        // Reset state observed while RESET is held low.
        #1;
        chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_readdata", 32'(READDATA), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_writedata", mem_writedata, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Directed vector table, memory latency 5.
        lat = 5;
        for (int i = 0; i < 7; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, st, ls);
            chk($sformatf("v%0d_stall", i), st, vecs[i].exp_stall);
            if (!vecs[i].wr) chk($sformatf("v%0d_readdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            n_exp = int'(vecs[i].exp_wb) + int'(vecs[i].exp_fetch);
            chk($sformatf("v%0d_num_mem_txn", i), mem_log.size() - ls, n_exp);
            if (mem_log.size() - ls == n_exp) begin
                k = ls;
                if (vecs[i].exp_wb) begin
                    chk($sformatf("v%0d_wb_is_write", i), 32'(mem_log[k].wr), 32'd1);
                    chk($sformatf("v%0d_wb_addr", i), 32'(mem_log[k].addr), 32'(vecs[i].wb_addr));
                    chk($sformatf("v%0d_wb_data", i), mem_log[k].data, vecs[i].wb_data);
                    k++;
                end
                if (vecs[i].exp_fetch) begin
                    chk($sformatf("v%0d_fetch_is_read", i), 32'(mem_log[k].wr), 32'd0);
                    chk($sformatf("v%0d_fetch_addr", i), 32'(mem_log[k].addr), 32'(vecs[i].fetch_addr));
                end
            end
`ifdef DCACHE_STATS_EN
            if (i == 1) begin
                chk("stats_cold_miss", 32'(miss_count), 32'd1);
                chk("stats_cold_hit", 32'(hit_count), 32'd1);
            end
`endif
        end
`ifdef DCACHE_STATS_EN
        chk("stats_table_miss", 32'(miss_count), 32'd5);
        chk("stats_table_hit", 32'(hit_count), 32'd2);
`endif

        // Reset while a fetch is outstanding.
        access(1'b0, 8'h25, 8'h00, rd, st, ls);
        chk("pre_rst_stall", st, 7);
        chk("pre_rst_readdata", 32'(rd), 32'hBB);
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 8'h45;
        @(posedge CLK);
        #2;
        chk("midfetch_mem_read", 32'(mem_read), 32'd1);
        chk("midfetch_mem_address", 32'(mem_address), 32'h11);
        #1;
        RESET = 1'b0;
        #1;
        chk("async_rst_mem_read", 32'(mem_read), 32'd0);
        chk("async_rst_mem_write", 32'(mem_write), 32'd0);
        @(negedge CLK);
        READ  = 1'b0;
        RESET = 1'b1;
        access(1'b0, 8'h25, 8'h00, rd, st, ls);
        chk("post_rst_remiss_stall", st, 7);
        chk("post_rst_readdata", 32'(rd), 32'hBB);
`ifdef DCACHE_STATS_EN
        chk("post_rst_miss_count", 32'(miss_count), 32'd1);
        chk("post_rst_hit_count", 32'(hit_count), 32'd0);
`endif

        // Randomized traffic against a flat byte-memory model.
        do_reset();
        for (int i = 0; i < 256; i++) ref_bytes[i] = mem[i >> 2][8 * (i % 4) +: 8];
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = 3'd0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        for (int n = 0; n < 400; n++) begin
            wr  = bit'($urandom_range(0, 1));
            a   = {3'($urandom_range(0, 2)), 5'($urandom)};
            wd  = 8'($urandom);
            lat = int'($urandom_range(1, 4));
            idx = a[4:2];
            tg  = a[7:5];
            if (mv[idx] && mt[idx] == tg) begin
                exp_stall = 0;
                if (wr) md[idx] = 1'b1;
                exp_hits++;
            end else begin
                exp_stall = ((mv[idx] && md[idx]) ? lat + 1 : 0) + lat + 2;
                mv[idx] = 1'b1;
                mt[idx] = tg;
                md[idx] = wr;
                exp_misses++;
            end
            access(wr, a, wd, rd, st, ls);
            chk($sformatf("rand%0d_stall addr=%0h", n, a), st, exp_stall);
            if (!wr) chk($sformatf("rand%0d_readdata addr=%0h", n, a), 32'(rd), 32'(ref_bytes[a]));
            else ref_bytes[a] = wd;
        end
`ifdef DCACHE_STATS_EN
        chk("rand_miss_count", 32'(miss_count), 32'(exp_misses));
        chk("rand_hit_count", 32'(hit_count), 32'(exp_hits));

        // Hold a hitting read long enough to saturate the hit counter.
        access(1'b0, 8'h00, 8'h00, rd, st, ls);
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 8'h00;
        repeat (65540) @(posedge CLK);
        #1;
        chk("hit_count_saturate", 32'(hit_count), 32'hFFFF);
        READ = 1'b0;
`endif

        chk("rd_wr_exclusive", both_high_seen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
